// File: rtl/dmem_pkg.sv
// Shared types and helpers for the RV32 data memory controller.
// Holds funct3 load/store encodings, FSM states and legality checks.
package dmem_pkg;

  typedef enum logic [2:0] {
    MT_B  = 3'b000,
    MT_H  = 3'b001,
    MT_W  = 3'b010,
    MT_BU = 3'b100,
    MT_HU = 3'b101
  } mem_type_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_e;

  function automatic logic is_legal(
    input logic [2:0] mem_type,
    input logic       we,
    input logic [1:0] addr_lo
  );
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      (mem_type == MT_B):  ok = 1'b1;
      (mem_type == MT_H):  ok = !addr_lo[0];
      (mem_type == MT_W):  ok = (addr_lo == 2'b00);
      (mem_type == MT_BU): ok = !we;
      (mem_type == MT_HU): ok = !we && !addr_lo[0];
      default:             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/response bundle between the MEM stage and the data memory.
// Signal names keep the controller-side direction prefixes.
interface dmem_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  i_req_valid;
  logic                  o_req_ready;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [DATA_WIDTH-1:0] i_wdata;
  logic                  i_we;
  logic [2:0]            i_mem_type;
  logic                  o_rsp_valid;
  logic                  i_rsp_ready;
  logic [DATA_WIDTH-1:0] o_rdata;
  logic                  o_err;

  modport master (
    output i_req_valid, i_addr, i_wdata,
    output i_we, i_mem_type, i_rsp_ready,
    input  o_req_ready, o_rsp_valid,
    input  o_rdata, o_err
  );

  modport slave (
    input  i_req_valid, i_addr, i_wdata,
    input  i_we, i_mem_type, i_rsp_ready,
    output o_req_ready, o_rsp_valid,
    output o_rdata, o_err
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32 loads and stores.
// Stores fan data out to lanes; loads pick a lane and extend it.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  mem_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext
);

  logic [7:0]  rb;
  logic [15:0] rh;

  assign rb = rword[{addr_lo, 3'b000} +: 8];
  assign rh = addr_lo[1] ? rword[31:16] : rword[15:0];

  // Store side: replicate data across lanes, enable only the target ones
  always_comb begin
    be       = 4'b0000;
    wdata_sh = '0;
    unique case (1'b1)
      (mem_type == MT_B): begin
        be       = 4'b0001 << addr_lo;
        wdata_sh = {4{wdata[7:0]}};
      end
      (mem_type == MT_H): begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_sh = {2{wdata[15:0]}};
      end
      (mem_type == MT_W): begin
        be       = 4'b1111;
        wdata_sh = wdata;
      end
      default: ;
    endcase
  end

  // Load side: move the selected lane to bit 0 and extend
  always_comb begin
    rdata_ext = '0;
    unique case (1'b1)
      (mem_type == MT_B):  rdata_ext = {{24{rb[7]}}, rb};
      (mem_type == MT_BU): rdata_ext = {24'h0, rb};
      (mem_type == MT_H):  rdata_ext = {{16{rh[15]}}, rh};
      (mem_type == MT_HU): rdata_ext = {16'h0, rh};
      (mem_type == MT_W):  rdata_ext = rword;
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// RV32 MEM-stage data memory with valid/ready handshakes.
// Optional wait states sit between acceptance and the memory commit.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input logic        i_clk,
  input logic        i_reset,
  dmem_ctrl_if.slave bus
);

  localparam int IW = $clog2(DEPTH_WORDS);

  if (DATA_WIDTH != 32) begin : g_dw_chk
    $error("dmem_ctrl: DATA_WIDTH must be 32");
  end
  if (DEPTH_WORDS < 2 || (1 << IW) != DEPTH_WORDS) begin : g_dp_chk
    $error("dmem_ctrl: DEPTH_WORDS must be a power of two >= 2");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_ws_chk
    $error("dmem_ctrl: WAIT_STATES must be 0..15");
  end

  dmem_state_e   state;
  logic [3:0]    cnt;
  logic          rdy_q;
  logic          vld_q;
  logic          err_q;
  logic [31:0]   rdata_q;
  logic [IW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          we_q;
  logic [2:0]    mt_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [IW+1:0] c_addr;
  logic [31:0]   c_wdata;
  logic          c_we;
  logic [2:0]    c_mt;
  logic [3:0]    be;
  logic [31:0]   wsh;
  logic [31:0]   rword;
  logic [31:0]   ext;
  logic          legal;
  logic          accept;
  logic          commit;
  logic          unused_bits;

  assign unused_bits = ^bus.i_addr;

  assign legal  = is_legal(bus.i_mem_type, bus.i_we,
                           bus.i_addr[1:0]);
  assign accept = bus.i_req_valid && rdy_q;

  // Commit uses the live request with no wait states, else the latched one
  always_comb begin
    c_addr  = bus.i_addr[IW+1:0];
    c_wdata = bus.i_wdata;
    c_we    = bus.i_we;
    c_mt    = bus.i_mem_type;
    if (state == WAIT) begin
      c_addr  = addr_q;
      c_wdata = wdata_q;
      c_we    = we_q;
      c_mt    = mt_q;
    end
  end

  assign commit = i_reset && (
    (accept && legal && (WAIT_STATES == 0)) ||
    (state == WAIT && cnt == 4'd0));

  assign rword = mem[c_addr[IW+1:2]];

  dmem_lane_align u_align (
    .mem_type  (c_mt),
    .addr_lo   (c_addr[1:0]),
    .wdata     (c_wdata),
    .rword     (rword),
    .be        (be),
    .wdata_sh  (wsh),
    .rdata_ext (ext)
  );

  // Storage is not reset; only enabled lanes change at the commit edge
  always_ff @(posedge i_clk) begin
    if (commit && c_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[c_addr[IW+1:2]][8*i +: 8] <= wsh[8*i +: 8];
        end
      end
    end
  end

  // Request/response FSM with registered handshake and result outputs
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      mt_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            addr_q  <= bus.i_addr[IW+1:0];
            wdata_q <= bus.i_wdata;
            we_q    <= bus.i_we;
            mt_q    <= bus.i_mem_type;
            rdy_q   <= 1'b0;
            if (!legal) begin
              state   <= RESP;
              vld_q   <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= '0;
            end else if (WAIT_STATES == 0) begin
              state   <= RESP;
              vld_q   <= 1'b1;
              err_q   <= 1'b0;
              rdata_q <= c_we ? 32'h0 : ext;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_STATES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state   <= RESP;
            vld_q   <= 1'b1;
            err_q   <= 1'b0;
            rdata_q <= c_we ? 32'h0 : ext;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.i_rsp_ready) begin
            state   <= IDLE;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
            err_q   <= 1'b0;
            rdata_q <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_req_ready = rdy_q;
  assign bus.o_rsp_valid = vld_q;
  assign bus.o_rdata     = rdata_q;
  assign bus.o_err       = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl across three configurations.
// Byte-array reference model plus directed vectors and random traffic.
module tb_dmem_ctrl;

  logic clk;
  logic rst_n [3];

  logic        t_valid     [3];
  logic        t_we        [3];
  logic        t_rsp_ready [3];
  logic [31:0] t_addr      [3];
  logic [31:0] t_wdata     [3];
  logic [2:0]  t_mt        [3];

  wire         o_ready [3];
  wire         o_valid [3];
  wire         o_err   [3];
  wire  [31:0] o_rdata [3];

  int total = 0;
  int bad   = 0;

  int ws_of [3] = '{0, 2, 3};
  int dp_of [3] = '{1024, 16, 64};

  logic [7:0] rmem [3][4096];

  dmem_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 0 : (g == 1) ? 2 : 3;
    localparam int DW = (g == 0) ? 1024 : (g == 1) ? 16 : 64;
    dmem_ctrl #(
      .ADDR_WIDTH  (32),
      .DATA_WIDTH  (32),
      .DEPTH_WORDS (DW),
      .WAIT_STATES (WS)
    ) u_dut (
      .i_clk   (clk),
      .i_reset (rst_n[g]),
      .bus     (bus[g])
    );
    assign bus[g].i_req_valid = t_valid[g];
    assign bus[g].i_addr      = t_addr[g];
    assign bus[g].i_wdata     = t_wdata[g];
    assign bus[g].i_we        = t_we[g];
    assign bus[g].i_mem_type  = t_mt[g];
    assign bus[g].i_rsp_ready = t_rsp_ready[g];
    assign o_ready[g] = bus[g].o_req_ready;
    assign o_valid[g] = bus[g].o_rsp_valid;
    assign o_err[g]   = bus[g].o_err;
    assign o_rdata[g] = bus[g].o_rdata;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Reference: byte-addressed memory, size/alignment rules, extension
  function automatic void model(
    input int d, input logic we, input logic [2:0] mt,
    input logic [31:0] a, input logic [31:0] wd,
    output logic [31:0] rd, output logic e);
    int sz;
    int b;
    logic [31:0] v;
    rd = '0;
    e  = 1'b0;
    sz = (mt[1:0] == 2'd0) ? 1 : (mt[1:0] == 2'd1) ? 2 : 4;
    if (mt == 3'd3 || mt == 3'd6 || mt == 3'd7 ||
        (we && mt[2]) || (a % 32'(sz)) != 0) begin
      e = 1'b1;
      return;
    end
    b = int'(a % 32'(dp_of[d] * 4));
    if (we) begin
      for (int i = 0; i < sz; i++) rmem[d][b+i] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = rmem[d][b+i];
      if (!mt[2] && sz < 4 && v[8*sz-1])
        for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
      rd = v;
    end
  endfunction

  task automatic xact(input string nm, input int d, input logic we,
                      input logic [2:0] mt, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] erd,
                      input logic ee, input int hold);
    int n;
    int lat;
    @(negedge clk);
    t_we[d]        = we;
    t_mt[d]        = mt;
    t_addr[d]      = a;
    t_wdata[d]     = wd;
    t_rsp_ready[d] = (hold == 0);
    t_valid[d]     = 1'b1;
    n = 0;
    while (o_ready[d] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      total++;
      bad++;
      $display("FAIL %s accept timeout", nm);
      t_valid[d]     = 1'b0;
      t_rsp_ready[d] = 1'b1;
      return;
    end
    @(posedge clk);
    #1;
    t_valid[d] = 1'b0;
    lat = 0;
    @(negedge clk);
    while (o_valid[d] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) begin
      total++;
      bad++;
      $display("FAIL %s response timeout", nm);
      t_rsp_ready[d] = 1'b1;
      return;
    end
    chk({nm, "_lat"}, 32'(lat), ee ? 32'd0 : 32'(ws_of[d]));
    chk({nm, "_rdata"}, o_rdata[d], erd);
    chk({nm, "_err"}, 32'(o_err[d]), 32'(ee));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, "_hold_vld"}, 32'(o_valid[d]), 32'd1);
      chk({nm, "_hold_rdy"}, 32'(o_ready[d]), 32'd0);
      chk({nm, "_hold_rdata"}, o_rdata[d], erd);
      chk({nm, "_hold_err"}, 32'(o_err[d]), 32'(ee));
    end
    t_rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          d;
    logic        we;
    logic [2:0]  mt;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        e;
  } vec_t;

  vec_t tv [$];

  initial begin
    logic [31:0] mrd;
    logic        me;
    logic [31:0] a;
    logic [31:0] wd;
    logic        we;
    logic [2:0]  mt;
    int          hold;

    tv.push_back('{0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0});
    tv.push_back('{0, 1'b0, 3'b000, 32'h101, 32'h0, 32'hFFFFFFBE, 1'b0});
    tv.push_back('{0, 1'b0, 3'b100, 32'h101, 32'h0, 32'h000000BE, 1'b0});
    tv.push_back('{0, 1'b0, 3'b001, 32'h102, 32'h0, 32'hFFFFDEAD, 1'b0});
    tv.push_back('{0, 1'b0, 3'b101, 32'h100, 32'h0, 32'h0000BEEF, 1'b0});
    tv.push_back('{0, 1'b1, 3'b000, 32'h103, 32'hAAAAAA11, 32'h0, 1'b0});
    tv.push_back('{0, 1'b0, 3'b010, 32'h100, 32'h0, 32'h11ADBEEF, 1'b0});
    tv.push_back('{0, 1'b1, 3'b010, 32'h200, 32'h0, 32'h0, 1'b0});
    tv.push_back('{0, 1'b1, 3'b001, 32'h200, 32'h1234CAFE, 32'h0, 1'b0});
    tv.push_back('{0, 1'b0, 3'b010, 32'h200, 32'h0, 32'h0000CAFE, 1'b0});
    tv.push_back('{0, 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1'b1});
    tv.push_back('{0, 1'b1, 3'b001, 32'h201, 32'hFFFF, 32'h0, 1'b1});
    tv.push_back('{0, 1'b1, 3'b100, 32'h200, 32'h55, 32'h0, 1'b1});
    tv.push_back('{0, 1'b0, 3'b111, 32'h200, 32'h0, 32'h0, 1'b1});
    tv.push_back('{0, 1'b0, 3'b010, 32'h200, 32'h0, 32'h0000CAFE, 1'b0});
    tv.push_back('{0, 1'b0, 3'b010, 32'h100, 32'h0, 32'h11ADBEEF, 1'b0});
    tv.push_back('{1, 1'b1, 3'b010, 32'h0, 32'h0, 32'h0, 1'b0});
    tv.push_back('{1, 1'b1, 3'b010, 32'h40, 32'h12345678, 32'h0, 1'b0});
    tv.push_back('{1, 1'b0, 3'b010, 32'h0, 32'h0, 32'h12345678, 1'b0});

    for (int d = 0; d < 3; d++) begin
      rst_n[d]       = 1'b0;
      t_valid[d]     = 1'b0;
      t_we[d]        = 1'b0;
      t_mt[d]        = 3'b010;
      t_addr[d]      = '0;
      t_wdata[d]     = '0;
      t_rsp_ready[d] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_rdy%0d", d), 32'(o_ready[d]), 32'd1);
      chk($sformatf("rst_vld%0d", d), 32'(o_valid[d]), 32'd0);
      chk($sformatf("rst_err%0d", d), 32'(o_err[d]), 32'd0);
      chk($sformatf("rst_rdata%0d", d), o_rdata[d], 32'd0);
    end
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;

    foreach (tv[i]) begin
      model(tv[i].d, tv[i].we, tv[i].mt, tv[i].a, tv[i].wd, mrd, me);
      xact($sformatf("vec%0d", i), tv[i].d, tv[i].we, tv[i].mt,
           tv[i].a, tv[i].wd, tv[i].rd, tv[i].e, 0);
    end

    xact("ws2_hold", 1, 1'b0, 3'b010, 32'h0, 32'h0,
         32'h12345678, 1'b0, 3);

    model(2, 1'b1, 3'b010, 32'h10, 32'hA5A5A5A5, mrd, me);
    xact("ws3_pre", 2, 1'b1, 3'b010, 32'h10, 32'hA5A5A5A5,
         32'h0, 1'b0, 0);
    @(negedge clk);
    t_we[2]    = 1'b1;
    t_mt[2]    = 3'b010;
    t_addr[2]  = 32'h10;
    t_wdata[2] = 32'h5A5A5A5A;
    t_valid[2] = 1'b1;
    @(posedge clk);
    #1;
    t_valid[2] = 1'b0;
    @(negedge clk);
    chk("ws3_busy_rdy", 32'(o_ready[2]), 32'd0);
    rst_n[2] = 1'b0;
    #1;
    chk("ws3_rst_rdy", 32'(o_ready[2]), 32'd1);
    chk("ws3_rst_vld", 32'(o_valid[2]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n[2] = 1'b1;
    @(negedge clk);
    chk("ws3_post_rdy", 32'(o_ready[2]), 32'd1);
    chk("ws3_post_vld", 32'(o_valid[2]), 32'd0);
    model(2, 1'b0, 3'b010, 32'h10, 32'h0, mrd, me);
    xact("ws3_old", 2, 1'b0, 3'b010, 32'h10, 32'h0, mrd, me, 0);

    for (int d = 0; d < 3; d++) begin
      for (int w = 0; w < 16; w++) begin
        a  = (d == 0) ? 32'h300 : (d == 1) ? 32'h0 : 32'h80;
        a  = a + 32'(4 * w);
        wd = $urandom;
        model(d, 1'b1, 3'b010, a, wd, mrd, me);
        xact($sformatf("init%0d_%0d", d, w), d, 1'b1, 3'b010,
             a, wd, mrd, me, 0);
      end
    end

    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 50; k++) begin
        we   = 1'($urandom_range(0, 1));
        mt   = 3'($urandom_range(0, 7));
        wd   = $urandom;
        hold = $urandom_range(0, 2);
        if (d == 0)
          a = 32'h300 + 32'($urandom_range(0, 63));
        else if (d == 1)
          a = $urandom;
        else
          a = ($urandom & 32'hFFFFFF00) |
              (32'h80 + 32'($urandom_range(0, 63)));
        model(d, we, mt, a, wd, mrd, me);
        xact($sformatf("rnd%0d_%0d", d, k), d, we, mt, a, wd,
             mrd, me, hold);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
